flit_rx_monitor: RTL and testbench

//  Receive-side monitor for the flit stream driven into the adder characterization datapath.
//  Re-assembles each 2N-bit flit from its lo/hi halves and frames packets as runs of valid cycles.
//  Per packet it reports length, bus toggle count (switching activity for energy estimation) and errors.

---
 rtl/flit_mon_pkg.sv | 33 +++
 rtl/flit_rx_monitor_popcount.sv | 19 +
 rtl/flit_rx_monitor.sv | 127 ++++++++++++
 tb/tb_flit_rx_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flit_mon_pkg.sv
// Shared types and helpers for the flit receive monitor.
package flit_mon_pkg;

    // Monitor framing state
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Default flit-half width and the matching popcount width
    localparam int unsigned DEF_N    = 26;
    localparam int unsigned POP_W    = $clog2(2 * DEF_N + 1);

    // Widest flit the pattern helper can describe; unused upper bits are zero
    localparam int unsigned PAT_MAXW = 256;

    // Reference flit for pattern slot idx: P0={1s,0s} P1={1s,1s} P2={0s,1s} P3={0s,0s}
    function automatic logic [PAT_MAXW-1:0] pattern(input logic [1:0] idx, input int unsigned n);
        logic                hi1;
        logic                lo1;
        logic [PAT_MAXW-1:0] p;
        hi1 = (idx == 2'd0) || (idx == 2'd1);
        lo1 = (idx == 2'd1) || (idx == 2'd2);
        p   = '0;
        for (int unsigned j = 0; j < PAT_MAXW; j++) begin
            if (j < 2 * n) begin
                p[j] = (j < n) ? lo1 : hi1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/flit_rx_monitor_popcount.sv
// Combinational population count of a W-bit word.
module flit_popcount #(
    parameter int unsigned W = 52
) (
    input  logic [W-1:0]             in,
    output logic [$clog2(W+1)-1:0]   cnt
);

    localparam int unsigned CW = $clog2(W + 1);

    // Sum every set bit of the input word
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt = cnt + CW'(in[i]);
        end
    end

endmodule

// File: rtl/flit_rx_monitor.sv
// Receive-side flit stream monitor: frames packets as runs of valid cycles
// and reports length, bus toggle activity and length/pattern errors.
// Optional: FLIT_PATTERN_CHECK_EN enables the P0..P3 flit pattern checker.
module flit_rx_monitor
    import flit_mon_pkg::*;
#(
    parameter int unsigned N       = 26,
    parameter int unsigned PAYLOAD = 20,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TOG_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in_lo,
    input  logic [N-1:0]     in_hi,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_len,
    output logic [TOG_W-1:0] pkt_toggles,
    output logic             len_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] pat_err_cnt
);

    localparam int unsigned FW   = 2 * N;
    localparam int unsigned PW   = $clog2(FW + 1);

    state_t             state;
    logic [FW-1:0]      prev_flit;
    logic [CNT_W-1:0]   len_acc;
    logic [TOG_W-1:0]   tog_acc;

    logic [FW-1:0]      flit;
    logic [PW-1:0]      pop;
    logic [TOG_W-1:0]   pop_ext;
    logic [TOG_W:0]     tog_sum;
    logic [TOG_W-1:0]   tog_next;
    logic [CNT_W-1:0]   len_next;

    assign flit = {in_hi, in_lo};

    flit_popcount #(.W(FW)) u_pop (
        .in  (flit ^ prev_flit),
        .cnt (pop)
    );

    // Saturating next values for the per-packet accumulators
    always_comb begin
        pop_ext  = TOG_W'(pop);
        tog_sum  = {1'b0, tog_acc} + {1'b0, pop_ext};
        tog_next = tog_sum[TOG_W] ? '1 : tog_sum[TOG_W-1:0];
        len_next = (len_acc == '1) ? '1 : len_acc + CNT_W'(1);
    end

    // Packet framing FSM with accumulators and registered report outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prev_flit   <= '0;
            len_acc     <= '0;
            tog_acc     <= '0;
            pkt_done    <= 1'b0;
            pkt_len     <= '0;
            pkt_toggles <= '0;
            len_err     <= 1'b0;
            pkt_count   <= '0;
        end else begin
            pkt_done <= 1'b0;
            if (in_valid) begin
                prev_flit <= flit;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= RECV;
                        len_acc <= CNT_W'(1);
                        tog_acc <= pop_ext;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        len_acc <= len_next;
                        tog_acc <= tog_next;
                    end else begin
                        state       <= IDLE;
                        pkt_done    <= 1'b1;
                        pkt_len     <= len_acc;
                        pkt_toggles <= tog_acc;
                        len_err     <= (len_acc != CNT_W'(PAYLOAD));
                        pkt_count   <= pkt_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FLIT_PATTERN_CHECK_EN
    logic [1:0]          pat_idx;
    logic [1:0]          cur_idx;
    logic [PAT_MAXW-1:0] exp_full;
    logic                pat_miss;

    // Pattern slot for this flit restarts at P0 on the first flit of a packet
    always_comb begin
        cur_idx  = (state == IDLE) ? 2'd0 : pat_idx;
        exp_full = pattern(cur_idx, N);
        pat_miss = (exp_full != {{(PAT_MAXW-FW){1'b0}}, flit});
    end

    // Advance the pattern slot per accepted flit and count mismatches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_idx     <= 2'd0;
            pat_err_cnt <= '0;
        end else if (in_valid) begin
            pat_idx <= cur_idx + 2'd1;
            if (pat_miss && (pat_err_cnt != '1)) begin
                pat_err_cnt <= pat_err_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign pat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_flit_rx_monitor.sv
// Scoreboard bench for flit_rx_monitor: directed and random packets, a
// packet-level reference model, and a monitor that checks every pkt_done.
module tb_flit_rx_monitor;

    localparam int N       = 26;
    localparam int FW      = 2 * N;
    localparam int PAYLOAD = 20;
    localparam int CNT_W   = 16;
    localparam int TOG_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [N-1:0]     in_lo = '0;
    logic [N-1:0]     in_hi = '0;

    logic             pkt_done;
    logic [CNT_W-1:0] pkt_len;
    logic [TOG_W-1:0] pkt_toggles;
    logic             len_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] pat_err_cnt;

    logic             d8_done;
    logic [CNT_W-1:0] d8_len;
    logic [7:0]       d8_toggles;
    logic             d8_len_err;
    logic [CNT_W-1:0] d8_count;
    logic [CNT_W-1:0] d8_pat;

    flit_rx_monitor #(.N(N), .PAYLOAD(PAYLOAD), .CNT_W(CNT_W), .TOG_W(TOG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_lo(in_lo), .in_hi(in_hi),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_toggles(pkt_toggles),
        .len_err(len_err), .pkt_count(pkt_count), .pat_err_cnt(pat_err_cnt)
    );

    flit_rx_monitor #(.N(N), .PAYLOAD(PAYLOAD), .CNT_W(CNT_W), .TOG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_lo(in_lo), .in_hi(in_hi),
        .pkt_done(d8_done), .pkt_len(d8_len), .pkt_toggles(d8_toggles),
        .len_err(d8_len_err), .pkt_count(d8_count), .pat_err_cnt(d8_pat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int len;
        int tog;
        int tog8;
        bit lerr;
        int cnt;
        int pat;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    logic [FW-1:0] m_prev = '0;
    int            m_count = 0;
    int            m_pat = 0;
    int            cur_len = 0;
    int            cur_tog = 0;
    bit            in_pkt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [FW-1:0] pat_of(input int k);
        logic [FW-1:0] p;
        case (k % 4)
            0:       p = {{N{1'b1}}, {N{1'b0}}};
            1:       p = {{N{1'b1}}, {N{1'b1}}};
            2:       p = {{N{1'b0}}, {N{1'b1}}};
            default: p = {{N{1'b0}}, {N{1'b0}}};
        endcase
        return p;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic drive_flit(input logic [FW-1:0] f);
        @(negedge clk);
        in_valid = 1'b1;
        {in_hi, in_lo} = f;
        if (!in_pkt) begin
            in_pkt  = 1;
            cur_len = 0;
            cur_tog = 0;
        end
`ifdef FLIT_PATTERN_CHECK_EN
        if (f != pat_of(cur_len)) m_pat++;
`endif
        cur_tog += $countones(f ^ m_prev);
        m_prev   = f;
        cur_len++;
    endtask

    task automatic drive_idle();
        exp_t e;
        @(negedge clk);
        in_valid = 1'b0;
        in_lo = N'($urandom);
        in_hi = N'($urandom);
        if (in_pkt) begin
            m_count++;
            e.len  = min_i(cur_len, 65535);
            e.tog  = min_i(cur_tog, 65535);
            e.tog8 = min_i(cur_tog, 255);
            e.lerr = (cur_len != PAYLOAD);
            e.cnt  = m_count & 16'hFFFF;
            e.pat  = min_i(m_pat, 65535);
            e.cyc  = cyc + 1;
            sbq.push_back(e);
            in_pkt = 0;
        end
    endtask

    // mode: 0 pattern, 1 random, 2 alternating 0s/1s, 3 pattern with flit 3 zeroed
    task automatic send_pkt(input int len, input int mode, input int gap);
        logic [63:0]   r;
        logic [FW-1:0] f;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0: f = pat_of(i);
                1: begin r = {$urandom, $urandom}; f = r[FW-1:0]; end
                2: f = (i % 2 == 1) ? {FW{1'b1}} : {FW{1'b0}};
                default: f = (i == 3) ? {FW{1'b0}} : pat_of(i);
            endcase
            drive_flit(f);
        end
        for (int g = 0; g < gap; g++) drive_idle();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        m_prev  = '0;
        m_count = 0;
        m_pat   = 0;
        in_pkt  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check({tag, "_pkt_done"},    pkt_done,    0);
        check({tag, "_pkt_len"},     pkt_len,     0);
        check({tag, "_pkt_toggles"}, pkt_toggles, 0);
        check({tag, "_len_err"},     len_err,     0);
        check({tag, "_pkt_count"},   pkt_count,   0);
        check({tag, "_pat_err_cnt"}, pat_err_cnt, 0);
    endtask

    // Monitor: every pkt_done pops one expected packet report
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (pkt_done || d8_done)) begin
            check("done_agree", d8_done, pkt_done);
            if (sbq.size() == 0) begin
                check("unexpected_pkt_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("done_latency", cyc, e.cyc);
                check("pkt_len",      pkt_len,     e.len);
                check("pkt_toggles",  pkt_toggles, e.tog);
                check("len_err",      len_err,     e.lerr);
                check("pkt_count",    pkt_count,   e.cnt);
                check("pat_err_cnt",  pat_err_cnt, e.pat);
                check("tog8_toggles", d8_toggles,  e.tog8);
                check("tog8_len",     d8_len,      e.len);
                check("tog8_len_err", d8_len_err,  e.lerr);
                check("tog8_count",   d8_count,    e.cnt);
                check("tog8_pat",     d8_pat,      e.pat);
            end
        end
    end

    initial begin
        do_reset("reset");

        for (int p = 0; p < 10; p++) send_pkt(PAYLOAD, 0, 7);
        send_pkt(19, 0, 3);
        send_pkt(21, 0, 3);
        send_pkt(PAYLOAD, 0, 1);
        send_pkt(PAYLOAD, 1, 1);
        send_pkt(PAYLOAD, 3, 5);
        send_pkt(PAYLOAD, 2, 4);

        send_pkt(10, 0, 0);
        do_reset("midreset");
        send_pkt(PAYLOAD, 0, 3);

        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(30, 1), $urandom_range(3, 0), $urandom_range(4, 1));
        end

        for (int g = 0; g < 10; g++) drive_idle();
        check("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #500000;
        $display("FAIL timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
